// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer code conversions and default geometry.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

   localparam int FIFO_ADDR_WIDTH = 6;
   localparam int FIFO_DATA_WIDTH = 8;

   // Conversions work on the widest supported pointer; callers size-cast in
   // and out. Zero-extended upper bits do not disturb the low-order result.
   localparam int FIFO_CODE_WIDTH = 32;

   typedef logic [FIFO_CODE_WIDTH-1:0] fifo_code_t;

   function automatic fifo_code_t bin2gray(input fifo_code_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic fifo_code_t gray2bin(input fifo_code_t g);
      fifo_code_t b;
      b[FIFO_CODE_WIDTH-1] = g[FIFO_CODE_WIDTH-1];
      for (int i = FIFO_CODE_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_out_reg.sv
// Registered valid/ready output stage for the FIFO read side.
// can_load tells the pointer logic when a new word may be popped into it.
module fifo_rd_out_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  can_load
);

   logic [DATA_WIDTH-1:0] dout_reg;
   logic                  valid_reg;

   // Empty slot, or the held word leaves this cycle: either way room exists.
   assign can_load = !valid_reg || dout_ready;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         dout_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         dout_reg  <= rdata;
         valid_reg <= 1'b1;
      end else if (valid_reg && dout_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign dout       = dout_reg;
   assign dout_valid = valid_reg;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer/empty controller for the async FIFO.
// Optional FIFO_RD_ALMOST_EMPTY_EN adds a registered almost_empty flag.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int AE_THRESH  = 4
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic [ADDR_WIDTH:0]   g_wptr_sync,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH:0]   b_rptr,
   output logic [ADDR_WIDTH:0]   g_rptr,
   output logic                  r_en,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  almost_empty
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] b_rptr_reg;
   logic [PTR_W-1:0] g_rptr_reg;
   logic [PTR_W-1:0] b_rptr_next;
   logic [PTR_W-1:0] g_rptr_next;
   logic             empty_reg;
   logic             can_load;
   logic             pop;

   // Gating on registered empty is what makes over-reading impossible.
   assign pop         = !rrst && !empty_reg && can_load;
   assign b_rptr_next = b_rptr_reg + {{(PTR_W-1){1'b0}}, pop};
   assign g_rptr_next = PTR_W'(bin2gray(FIFO_CODE_WIDTH'(b_rptr_next)));

   always_ff @(posedge rclk) begin
      if (rrst) begin
         b_rptr_reg <= '0;
         g_rptr_reg <= '0;
         empty_reg  <= 1'b1;
      end else begin
         b_rptr_reg <= b_rptr_next;
         g_rptr_reg <= g_rptr_next;
         empty_reg  <= (g_rptr_next == g_wptr_sync);
      end
   end

   fifo_rd_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .rclk       (rclk),
      .rrst       (rrst),
      .load       (pop),
      .rdata      (rdata),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .can_load   (can_load)
   );

`ifdef FIFO_RD_ALMOST_EMPTY_EN
   localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(AE_THRESH);

   logic [PTR_W-1:0] wptr_bin;
   logic [PTR_W-1:0] level;
   logic             almost_empty_reg;

   // Level counts words still in memory; the word parked in dout is excluded.
   assign wptr_bin = PTR_W'(gray2bin(FIFO_CODE_WIDTH'(g_wptr_sync)));
   assign level    = wptr_bin - b_rptr_next;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         almost_empty_reg <= 1'b1;
      end else begin
         almost_empty_reg <= (level <= AE_LEVEL);
      end
   end

   assign almost_empty = almost_empty_reg;
`else
   assign almost_empty = 1'b0;
`endif

   assign b_rptr = b_rptr_reg;
   assign g_rptr = g_rptr_reg;
   assign empty  = empty_reg;
   assign r_en   = pop;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a stimulus thread plays the writer and
// queues expected words; a monitor pops and compares on every accepted word.
module tb_fifo_rd_ctrl;

   localparam int AW = 6;
   localparam int DW = 8;
   localparam int PW = AW + 1;

   logic          rclk = 1'b0;
   logic          rrst = 1'b1;
   logic [PW-1:0] g_wptr_sync = 7'h05;
   logic [DW-1:0] rdata;
   logic [PW-1:0] b_rptr;
   logic [PW-1:0] g_rptr;
   logic          r_en;
   logic          empty;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic          almost_empty;

   logic [DW-1:0] mem [64];
   logic [PW-1:0] wptr = '0;
   logic [DW-1:0] exp_q [$];
   int            accepted = 0;
   int            n_checks = 0;
   int            n_fail = 0;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
   localparam logic AE_RST = 1'b1;
   localparam logic [11:0] AE_TBL = 12'b1111_1100_0000;
`else
   localparam logic AE_RST = 1'b0;
   localparam logic [11:0] AE_TBL = 12'b0000_0000_0000;
`endif
   localparam logic [11:0] EMPTY_TBL = 12'b1100_0000_0000;

   fifo_rd_ctrl dut (
      .rclk         (rclk),
      .rrst         (rrst),
      .g_wptr_sync  (g_wptr_sync),
      .rdata        (rdata),
      .b_rptr       (b_rptr),
      .g_rptr       (g_rptr),
      .r_en         (r_en),
      .empty        (empty),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .almost_empty (almost_empty)
   );

   assign rdata = mem[b_rptr[AW-1:0]];

   always #5 rclk = ~rclk;

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check7(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check8(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checki(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   // Writer model: store the word, queue it as expected, publish the Gray pointer.
   task automatic write_word(input logic [DW-1:0] d);
      mem[wptr[AW-1:0]] = d;
      exp_q.push_back(d);
      wptr = wptr + 7'd1;
      g_wptr_sync = wptr ^ (wptr >> 1);
      $display("write addr=%0d data=%02h g_wptr_sync=%02h", wptr - 7'd1, d, g_wptr_sync);
   endtask

   task automatic do_reset();
      rrst = 1'b1;
      dout_ready = 1'b0;
      wptr = '0;
      g_wptr_sync = '0;
      exp_q.delete();
      tick();
      tick();
      accepted = 0;
      rrst = 1'b0;
   endtask

   // Monitor: every word the consumer accepts must be the next queued word.
   always @(negedge rclk) begin
      if (!rrst && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %02h expected none", dout);
         end else begin
            $display("read data=%02h expected=%02h", dout, exp_q[0]);
            check8("dout_stream", dout, exp_q.pop_front());
         end
         accepted++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [PW-1:0] prev_b;
      logic [PW-1:0] prev_g;
      int            bubbles;
      int            addr_wraps;
      logic          b_wrap;
      logic          g_wrap;
      int            written;
      int            cyc;

      for (int i = 0; i < 64; i++) mem[i] = '0;

      // Reset with a nonzero write pointer present.
      tick();
      tick();
      check7("rst_b_rptr", b_rptr, 7'h00);
      check7("rst_g_rptr", g_rptr, 7'h00);
      check1("rst_empty", empty, 1'b1);
      check1("rst_dout_valid", dout_valid, 1'b0);
      check1("rst_r_en", r_en, 1'b0);
      check8("rst_dout", dout, 8'h00);
      check1("rst_almost_empty", almost_empty, AE_RST);

      // Single word.
      do_reset();
      dout_ready = 1'b1;
      write_word(8'hA5);
      tick();
      check1("sw_empty_fall", empty, 1'b0);
      check1("sw_r_en", r_en, 1'b1);
      tick();
      check1("sw_valid", dout_valid, 1'b1);
      check8("sw_dout", dout, 8'hA5);
      check7("sw_b_rptr", b_rptr, 7'h01);
      check7("sw_g_rptr", g_rptr, 7'h01);
      check1("sw_empty_rise", empty, 1'b1);
      tick();
      check1("sw_valid_clear", dout_valid, 1'b0);

      // Backpressure: first word must hold while ready is low.
      do_reset();
      write_word(8'h11);
      write_word(8'h22);
      write_word(8'h33);
      tick();
      tick();
      tick();
      tick();
      check8("bp_dout_hold", dout, 8'h11);
      check1("bp_valid_hold", dout_valid, 1'b1);
      check7("bp_b_rptr_hold", b_rptr, 7'h01);
      dout_ready = 1'b1;
      tick();
      check8("bp_dout_2", dout, 8'h22);
      tick();
      check8("bp_dout_3", dout, 8'h33);
      check1("bp_empty", empty, 1'b1);
      check7("bp_b_rptr", b_rptr, 7'h03);
      tick();
      check1("bp_valid_clear", dout_valid, 1'b0);

      // Almost-empty: ten words, ready high, walk the flag per edge.
      do_reset();
      dout_ready = 1'b1;
      for (int i = 0; i < 10; i++) write_word(8'(8'h40 + i));
      for (int k = 0; k < 12; k++) begin
         tick();
         check1($sformatf("ae_edge%0d", k + 1), almost_empty, AE_TBL[k]);
         check1($sformatf("ae_empty_edge%0d", k + 1), empty, EMPTY_TBL[k]);
      end
      checki("ae_accepted", accepted, 10);

      // Wrap: 130 words streamed with the writer staying ahead.
      do_reset();
      dout_ready = 1'b1;
      written = 0;
      for (int i = 0; i < 4; i++) begin
         write_word(8'(written * 37 + 5));
         written++;
      end
      prev_b = '0;
      prev_g = '0;
      bubbles = 0;
      addr_wraps = 0;
      b_wrap = 1'b0;
      g_wrap = 1'b0;
      cyc = 0;
      while (accepted < 130 && cyc < 400) begin
         tick();
         cyc++;
         if (prev_b == 7'd127 && b_rptr == 7'd0) b_wrap = 1'b1;
         if (prev_g == 7'h40 && g_rptr == 7'h00) g_wrap = 1'b1;
         if (prev_b[AW-1:0] == 6'd63 && b_rptr[AW-1:0] == 6'd0) addr_wraps++;
         if (accepted > 0 && accepted < 130 && !dout_valid) bubbles++;
         prev_b = b_rptr;
         prev_g = g_rptr;
         if (written < 130) begin
            write_word(8'(written * 37 + 5));
            written++;
         end
      end
      checki("wrap_accepted", accepted, 130);
      check1("wrap_b_127_to_0", b_wrap, 1'b1);
      check1("wrap_g_40_to_00", g_wrap, 1'b1);
      checki("wrap_addr_63_to_0", addr_wraps, 2);
      checki("wrap_bubbles", bubbles, 0);
      tick();
      check7("wrap_b_final", b_rptr, 7'd2);
      check7("wrap_g_final", g_rptr, 7'h03);
      check1("wrap_empty_final", empty, 1'b1);
      checki("wrap_queue_drained", exp_q.size(), 0);

      // Reset while a word is held under backpressure.
      do_reset();
      write_word(8'hC1);
      write_word(8'hC2);
      tick();
      tick();
      check1("mr_valid_before", dout_valid, 1'b1);
      check8("mr_dout_before", dout, 8'hC1);
      rrst = 1'b1;
      tick();
      check1("mr_valid", dout_valid, 1'b0);
      check8("mr_dout", dout, 8'h00);
      check7("mr_b_rptr", b_rptr, 7'h00);
      check7("mr_g_rptr", g_rptr, 7'h00);
      check1("mr_empty", empty, 1'b1);
      check1("mr_r_en", r_en, 1'b0);
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
